// File: rtl/regfile_dump_ctrl.sv
// Register-file dump initiator: sweeps every address on an async read port and
// streams each word MSB byte first on an 8-bit valid/ready link, then an XOR checksum.
module regfile_dump_ctrl #(
  parameter int unsigned WD   = 32,
  parameter int unsigned SEL  = 5,
  parameter int unsigned NREG = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start_i,
  output logic [SEL-1:0] rd_addr_o,
  input  logic [WD-1:0]  rd_data_i,
  output logic [7:0]     tx_data_o,
  output logic           tx_valid_o,
  input  logic           tx_ready_i,
  output logic           busy_o,
  output logic           done_o
);

  localparam int unsigned NBYTES = WD / 8;
  localparam int unsigned BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
  localparam logic [SEL-1:0] LAST_ADDR = SEL'(NREG - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_CSUM,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [SEL-1:0] addr_q, addr_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [WD-1:0]  shift_q, shift_d;
  logic [7:0]     csum_q, csum_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           tx_valid_q, tx_valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           xfer;

  // Handshake is judged on the registered valid, so valid never depends on ready.
  assign xfer = tx_valid_q & tx_ready_i;

  // Next-state and datapath; outputs are decoded from the next state and registered.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    csum_d     = csum_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LOAD;
          addr_d  = '0;
          csum_d  = '0;
        end
      end
      S_LOAD: begin
        shift_d    = rd_data_i;
        byte_cnt_d = '0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
          csum_d     = csum_q ^ tx_data_q;
          shift_d    = shift_q << 8;
          byte_cnt_d = byte_cnt_q + BCW'(1);
          if (byte_cnt_q == LAST_BYTE) begin
            if (addr_q == LAST_ADDR) begin
              state_d = S_CSUM;
            end else begin
              addr_d  = addr_q + SEL'(1);
              state_d = S_LOAD;
            end
          end
        end
      end
      S_CSUM: begin
        if (xfer) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Data only changes when entering a byte slot, so it holds through stalls.
    if (state_d == S_SEND) begin
      tx_data_d  = shift_d[WD-1 -: 8];
      tx_valid_d = 1'b1;
    end else if (state_d == S_CSUM) begin
      tx_data_d  = csum_d;
      tx_valid_d = 1'b1;
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      csum_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      csum_q     <= csum_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rd_addr_o  = addr_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench for regfile_dump_ctrl: a behavioural register file feeds the read
// port and each scenario task checks the streamed bytes against expectations.
module tb_regfile_dump_ctrl;

  localparam int unsigned WD   = 32;
  localparam int unsigned SEL  = 5;
  localparam int unsigned NREG = 32;
  localparam int unsigned NB   = WD / 8;
  localparam int TOTAL_CYC     = 163;
  localparam int MAX_CYC       = 3000;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start_i = 1'b0;
  logic [SEL-1:0] rd_addr_o;
  logic [WD-1:0]  rd_data_i;
  logic [7:0]     tx_data_o;
  logic           tx_valid_o;
  logic           tx_ready_i = 1'b0;
  logic           busy_o;
  logic           done_o;

  logic [WD-1:0] rf [NREG];
  logic [7:0]    exp_q[$];
  logic [7:0]    got_q[$];
  int checks = 0;
  int errors = 0;

  assign rd_data_i = rf[rd_addr_o];

  always #5 clk = ~clk;

  regfile_dump_ctrl #(.WD(WD), .SEL(SEL), .NREG(NREG)) dut (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start_i),
    .rd_addr_o (rd_addr_o),
    .rd_data_i (rd_data_i),
    .tx_data_o (tx_data_o),
    .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  task automatic load_pattern();
    for (int i = 0; i < NREG; i++) rf[i] = 32'h01010101 * i;
  endtask

  // Expected stream from the current register contents: data bytes then checksum.
  task automatic build_exp();
    logic [7:0] c;
    logic [WD-1:0] w;
    exp_q = {};
    c = 8'h00;
    for (int i = 0; i < NREG; i++) begin
      w = rf[i];
      for (int b = NB - 1; b >= 0; b--) begin
        exp_q.push_back(w[b*8 +: 8]);
        c = c ^ w[b*8 +: 8];
      end
    end
    exp_q.push_back(c);
  endtask

  // Entered 1 time unit after a rising edge; leaves the same way.
  task automatic start_dump(input bit hold);
    start_i = 1'b1;
    @(posedge clk); #1;
    if (!hold) start_i = 1'b0;
  endtask

  // Records accepted bytes until done_o is seen; flags data/valid changes during stalls.
  task automatic collect(input bit rnd, output int cycles, output int stall_err, output bit timeout);
    logic       v, had_stall, r;
    logic [7:0] d, held;
    got_q = {};
    cycles = 1;
    stall_err = 0;
    timeout = 1'b1;
    had_stall = 1'b0;
    held = 8'h00;
    for (int n = 0; n < MAX_CYC; n++) begin
      if (done_o === 1'b1) begin
        timeout = 1'b0;
        break;
      end
      v = tx_valid_o;
      d = tx_data_o;
      if (had_stall && (v !== 1'b1 || d !== held)) stall_err++;
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tx_ready_i = r;
      @(posedge clk); #1;
      cycles++;
      if (v && r) got_q.push_back(d);
      had_stall = v && !r;
      held = d;
    end
    tx_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({rd_addr_o, tx_data_o, tx_valid_o, busy_o, done_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%0d data=%h valid=%b busy=%b done=%b, want all 0",
               rd_addr_o, tx_data_o, tx_valid_o, busy_o, done_o);
    end
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0 || tx_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b valid=%b, want 0 0", busy_o, tx_valid_o);
    end
  endtask

  task automatic test_basic();
    int cyc, serr, first;
    bit to;
    load_pattern();
    build_exp();
    start_dump(1'b0);
    collect(1'b0, cyc, serr, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL basic_timeout: no done_o within %0d cycles", MAX_CYC);
    end
    first = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (first < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) first = i;
    checks++;
    if (first >= 0 || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_bytes: first diff idx=%0d got_n=%0d want_n=%0d", first, got_q.size(), exp_q.size());
    end
    checks++;
    if (got_q.size() > 0 && got_q[got_q.size()-1] !== 8'h00) begin
      errors++;
      $display("FAIL basic_csum: got %h want 00", got_q[got_q.size()-1]);
    end
    // Count includes the cycle in which start_i was sampled.
    checks++;
    if (cyc + 1 != TOTAL_CYC) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles want %0d", cyc + 1, TOTAL_CYC);
    end
    @(posedge clk); #1;
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_once: got done=%b busy=%b want 0 0", done_o, busy_o);
    end
  endtask

  task automatic test_single_word();
    int cyc, serr;
    bit to;
    for (int i = 0; i < NREG; i++) rf[i] = '0;
    rf[0] = 32'hDEADBEEF;
    start_dump(1'b0);
    collect(1'b0, cyc, serr, to);
    checks++;
    if (to || got_q.size() != 129) begin
      errors++;
      $display("FAIL single_count: got %0d bytes timeout=%b want 129", got_q.size(), to);
    end else begin
      checks++;
      if ({got_q[0], got_q[1], got_q[2], got_q[3]} !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL single_first: got %h%h%h%h want deadbeef", got_q[0], got_q[1], got_q[2], got_q[3]);
      end
      checks++;
      if (got_q[128] !== 8'h22) begin
        errors++;
        $display("FAIL single_csum: got %h want 22", got_q[128]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    int cyc, serr, first;
    bit to;
    load_pattern();
    build_exp();
    start_dump(1'b0);
    collect(1'b1, cyc, serr, to);
    first = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (first < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) first = i;
    checks++;
    if (to || first >= 0 || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL stall_bytes: first diff idx=%0d got_n=%0d want_n=%0d timeout=%b",
               first, got_q.size(), exp_q.size(), to);
    end
    checks++;
    if (serr != 0) begin
      errors++;
      $display("FAIL stall_stable: got %0d unstable stall cycles want 0", serr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_held();
    int cyc, serr, first;
    bit to;
    load_pattern();
    build_exp();
    start_dump(1'b1);
    collect(1'b0, cyc, serr, to);
    checks++;
    if (to || cyc + 1 != TOTAL_CYC || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL held_first_dump: got %0d cycles %0d bytes want %0d cycles %0d bytes",
               cyc + 1, got_q.size(), TOTAL_CYC, exp_q.size());
    end
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL held_idle_gap: got busy=%b done=%b want 0 0", busy_o, done_o);
    end
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b1 || tx_valid_o !== 1'b0 || rd_addr_o !== 5'd0) begin
      errors++;
      $display("FAIL held_restart: got busy=%b valid=%b addr=%0d want 1 0 0", busy_o, tx_valid_o, rd_addr_o);
    end
    start_i = 1'b0;
    collect(1'b0, cyc, serr, to);
    first = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (first < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) first = i;
    checks++;
    if (to || first >= 0 || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL held_second_dump: first diff idx=%0d got_n=%0d want_n=%0d", first, got_q.size(), exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int cyc, serr, first;
    bit to, saw_done;
    load_pattern();
    rf[0] = 32'hC3A55A3C;
    build_exp();
    tx_ready_i = 1'b1;
    start_dump(1'b0);
    // Register k byte b is presented in cycle 2 + 5k + b; register 7 byte 2 is cycle 39.
    repeat (38) @(posedge clk);
    #1;
    checks++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h07 || rd_addr_o !== 5'd7) begin
      errors++;
      $display("FAIL abort_position: got valid=%b data=%h addr=%0d want 1 07 7", tx_valid_o, tx_data_o, rd_addr_o);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (tx_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_immediate: got valid=%b busy=%b done=%b want 0 0 0", tx_valid_o, busy_o, done_o);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done_o !== 1'b0) saw_done = 1'b1;
    end
    #1 reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done_o !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done || rd_addr_o !== 5'd0) begin
      errors++;
      $display("FAIL abort_no_done: got saw_done=%b addr=%0d want 0 0", saw_done, rd_addr_o);
    end
    start_dump(1'b0);
    collect(1'b0, cyc, serr, to);
    first = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (first < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) first = i;
    checks++;
    if (to || first >= 0 || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL abort_redump: first diff idx=%0d got_n=%0d want_n=%0d", first, got_q.size(), exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_late_write();
    int cyc, serr, first;
    bit to, wrote;
    logic [7:0] x;
    load_pattern();
    build_exp();
    wrote = 1'b0;
    start_dump(1'b0);
    fork
      collect(1'b0, cyc, serr, to);
      begin
        for (int n = 0; n < 200; n++) begin
          @(posedge clk); #2;
          if (rd_addr_o == 5'd5 && tx_valid_o === 1'b1) begin
            rf[5] = 32'hFFFF0000;
            wrote = 1'b1;
            break;
          end
        end
      end
    join
    checks++;
    if (!wrote) begin
      errors++;
      $display("FAIL late_write_setup: got wrote=0 want 1");
    end
    first = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (first < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) first = i;
    checks++;
    if (to || first >= 0 || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL late_write_bytes: first diff idx=%0d got_n=%0d want_n=%0d", first, got_q.size(), exp_q.size());
    end
    x = 8'h00;
    for (int i = 0; i + 1 < got_q.size(); i++) x = x ^ got_q[i];
    checks++;
    if (got_q.size() == 0 || got_q[got_q.size()-1] !== x) begin
      errors++;
      $display("FAIL late_write_csum: got %h want %h", (got_q.size() > 0) ? got_q[got_q.size()-1] : 8'h00, x);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_word();
    test_stall();
    test_start_held();
    test_abort();
    test_late_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_dump_ctrl.md
Name: regfile_dump_ctrl

Overview:
Read-side initiator for the register file. On a start pulse it sweeps every register address on one asynchronous read port and captures each word. It serializes the words MSB byte first onto an 8-bit valid/ready stream, then sends a trailing XOR checksum byte. It is used for debug and state dumps; it only drives a read-port address and never writes the register file.

Parameters:
WD, 32, register data width; must be a multiple of 8
SEL, 5, register address width
NREG, 32, number of registers swept (addresses 0..NREG-1); NREG <= 2**SEL

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start_i  input  1  start-dump request, sampled in IDLE only
rd_addr_o  output  SEL  register address to the register file read port
rd_data_i  input  WD  read data from the register file; combinational (same-cycle) read
tx_data_o  output  8  stream byte
tx_valid_o  output  1  stream byte valid
tx_ready_i  input  1  sink ready; transfer happens when tx_valid_o & tx_ready_i at a rising edge
busy_o  output  1  high in every state except IDLE
done_o  output  1  one-cycle pulse after the checksum byte transfers

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE.
- Reset values: rd_addr_o=0, tx_data_o=0, tx_valid_o=0, busy_o=0, done_o=0; address counter, byte counter, shift register and checksum all cleared.
- Reset asserted mid-dump aborts immediately: tx_valid_o drops without waiting for tx_ready_i, and no done_o pulse is produced.
- States: IDLE, LOAD, SEND, CSUM, DONE.
- IDLE: on start_i=1, go to LOAD with addr=0 and checksum=0. start_i is ignored in every other state; there is no queuing.
- LOAD (1 cycle): rd_addr_o=addr.
  - Capture rd_data_i into the WD-bit shift register at the clock edge.
  - Set byte_cnt=0 and go to SEND.
- SEND:
  - tx_valid_o=1; tx_data_o = shift[WD-1:WD-8] (MSB byte first).
  - On transfer: checksum ^= tx_data_o, shift <<= 8, byte_cnt++.
  - After the transfer with byte_cnt=WD/8-1:
    - if addr==NREG-1, go to CSUM;
    - else addr++ and go to LOAD.
- CSUM: tx_valid_o=1, tx_data_o=checksum (XOR of all data bytes). On transfer, go to DONE.
- DONE (1 cycle): done_o=1, then go to IDLE. busy_o=1 in DONE.
- Stream rules:
  - While tx_valid_o=1 and tx_ready_i=0, tx_data_o holds stable and tx_valid_o stays high.
  - tx_valid_o never depends combinationally on tx_ready_i.
  - tx_valid_o is 0 in IDLE, LOAD and DONE, so a one-cycle bubble occurs between registers.
- rd_addr_o holds its value outside LOAD. Register content is sampled only in LOAD; writes to that register after LOAD are not reflected in the dump.
- Latency with tx_ready_i held 1:
  - start_i sampled at edge 0; first tx_valid_o high in the cycle after LOAD (cycle 2).
  - Per register: 1 + WD/8 cycles.
  - Total from start to done_o: 1 + NREG*(1+WD/8) + 1 + 1 cycles, i.e. 163 for the defaults.
- Address counter is SEL bits wide; termination is by comparison with NREG-1, never by wrap-around.

Test Plan:
1. Registers preloaded with r[i]=0x01010101*i, tx_ready_i=1, start_i pulsed.
   -> 128 data bytes in order 00 00 00 00, 01 01 01 01, ..., 1F 1F 1F 1F, then checksum 0x00; done_o pulses exactly once, 163 cycles after start.
2. r[0]=0xDEADBEEF, all other registers 0.
   -> first bytes DE AD BE EF, checksum 0xDE^0xAD^0xBE^0xEF = 0x22.
3. tx_ready_i random with 50% duty.
   -> byte sequence identical to scenario 1; tx_data_o stable while stalled; no byte dropped or duplicated.
4. start_i held high through the whole dump and after done_o.
   -> first dump is unaffected; a second dump starts on the IDLE cycle after DONE.
5. reset driven low during SEND of register 7, byte 2.
   -> tx_valid_o=0 and busy_o=0 immediately; no done_o; a new start_i dumps from r[0].
6. Register 5 written during the dump, after its LOAD cycle.
   -> the stream carries the old value of r[5]; the checksum matches the streamed bytes.
